// File: rtl/shift_reg_seq.sv
// shift_reg_seq
//   WIDTH-bit register bank with an INIT reset value, enable, parallel load,
//   shift/rotate/clear/invert modes and a counted multi-shift sequencer.
//   Doubles as a general state/data register and as a serialiser.
// Ports
//   clk     rising-edge clock
//   reset   synchronous, active-high; overrides every other input
//   en      direct-op enable in IDLE, pause (when 0) in RUN
//   mode    000 hold,001 load,010 shl,011 shr,100 rotl,101 rotr,110 clear,111 invert
//   d       parallel load data
//   sin     serial in (LSB on shl, MSB on shr; unused by rotates)
//   start   request a sequence of nshift shifts in the sampled mode
//   nshift  number of shifts for the sequence
//   q       register contents
//   sout    last bit shifted/rotated out (registered)
//   busy    sequencer in RUN
//   done    one-cycle pulse after a sequence completes
module shift_reg_seq #(
  parameter int                WIDTH = 8,
  parameter logic [WIDTH-1:0]  INIT  = '0,
  parameter int                CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CNT_W-1:0] nshift,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROTL = 3'b100;
  localparam logic [2:0] M_ROTR = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;
  localparam logic [2:0] M_INV  = 3'b111;

  logic [0:0]       state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  logic             is_shift;
  logic [2:0]       op_mode;
  logic [WIDTH-1:0] q_n;
  logic             sout_n;

  // Shift/rotate modes are exactly 010..101, i.e. mode[2] != mode[1].
  assign is_shift = mode[2] ^ mode[1];
  // In RUN the mode latched with start drives the datapath; live mode is ignored.
  assign op_mode  = (state_q == S_RUN) ? mode_q : mode;

  // Result of applying op_mode once to the current register.
  always_comb begin
    q_n    = q_q;
    sout_n = sout_q;
    case (op_mode)
      M_HOLD: q_n = q_q;
      M_LOAD: q_n = d;
      M_SHL: begin
        q_n    = {q_q[WIDTH-2:0], sin};
        sout_n = q_q[WIDTH-1];
      end
      M_SHR: begin
        q_n    = {sin, q_q[WIDTH-1:1]};
        sout_n = q_q[0];
      end
      M_ROTL: begin
        q_n    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        sout_n = q_q[WIDTH-1];
      end
      M_ROTR: begin
        q_n    = {q_q[0], q_q[WIDTH-1:1]};
        sout_n = q_q[0];
      end
      M_CLR:   q_n = INIT;
      M_INV:   q_n = ~q_q;
      default: q_n = q_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    if (state_q == S_IDLE) begin
      // start wins over a direct op and needs no en; non-shift modes make it a no-op.
      if (start && is_shift) begin
        if (nshift == '0) begin
          done_d = 1'b1;
        end else begin
          state_d = S_RUN;
          mode_d  = mode;
          cnt_d   = nshift;
        end
      end else if (en) begin
        q_d    = q_n;
        sout_d = sout_n;
      end
    end else if (en) begin
      q_d    = q_n;
      sout_d = sout_n;
      cnt_d  = cnt_q - CNT_W'(1);
      // Leave on the last shift so the count never wraps below 1.
      if (cnt_q == CNT_W'(1)) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= M_HOLD;
      cnt_q   <= '0;
      q_q     <= INIT;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = (state_q == S_RUN);
  assign done = done_q;

endmodule

// File: tb/tb_shift_reg_seq.sv
module tb_shift_reg_seq;
  localparam int         W     = 8;
  localparam logic [7:0] INITV = 8'hA5;
  localparam int         CW    = 4;

  logic          clk = 1'b0;
  logic          reset, en, sin, start;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic [CW-1:0] nshift;
  logic [W-1:0]  q;
  logic          sout, busy, done;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Reference model state
  logic [7:0] mq;
  logic       ms, mb, md;
  logic [2:0] mm;
  int         mcnt;

  shift_reg_seq #(.WIDTH(W), .INIT(INITV), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .sin(sin),
    .start(start), .nshift(nshift), .q(q), .sout(sout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic apply(input logic [2:0] m);
    case (m)
      3'd1: mq = d;
      3'd2: begin ms = mq[7]; mq = (mq << 1) | {7'd0, sin}; end
      3'd3: begin ms = mq[0]; mq = (mq >> 1) | (sin ? 8'h80 : 8'h00); end
      3'd4: begin ms = mq[7]; mq = (mq << 1) | (mq >> 7); end
      3'd5: begin ms = mq[0]; mq = (mq >> 1) | (mq << 7); end
      3'd6: mq = INITV;
      3'd7: mq = ~mq;
      default: ;
    endcase
  endtask

  task automatic model_update();
    logic nd;
    nd = 1'b0;
    if (reset) begin
      mq = INITV; ms = 1'b0; mb = 1'b0; mcnt = 0;
    end else if (!mb) begin
      if (start && mode >= 3'd2 && mode <= 3'd5) begin
        if (nshift == 0) nd = 1'b1;
        else begin mb = 1'b1; mcnt = int'(nshift); mm = mode; end
      end else if (en) apply(mode);
    end else if (en) begin
      apply(mm);
      mcnt = mcnt - 1;
      if (mcnt == 0) begin mb = 1'b0; nd = 1'b1; end
    end
    md = nd;
  endtask

  // Inputs are stable across the posedge, so the model samples them right after it.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      total++;
      if (q !== mq || sout !== ms || busy !== mb || done !== md) begin
        bad++;
        $display("FAIL model t=%0t q=%h/%h sout=%b/%b busy=%b/%b done=%b/%b (got/exp)",
                 $time, q, mq, sout, ms, busy, mb, done, md);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic setin(input logic e, input logic [2:0] m, input logic [7:0] dd,
                       input logic s, input logic st, input logic [3:0] n);
    en = e; mode = m; d = dd; sin = s; start = st; nshift = n;
  endtask

  initial begin
    int nb, g, ndone;
    reset = 1'b1;
    setin(1'b1, 3'b001, 8'hFF, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    tick(); tick();
    chk_on = 1'b1;
    chk("rst_q", {24'd0, q}, 32'hA5);
    chk("rst_flags", {29'd0, sout, busy, done}, 32'd0);
    reset = 1'b0;

    // load then rotate left/right
    setin(1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 4'd0); tick();
    chk("load", {24'd0, q}, 32'h81);
    mode = 3'b100; tick();
    chk("rotl", {23'd0, q, sout}, {23'd0, 8'h03, 1'b1});
    mode = 3'b101; tick();
    chk("rotr", {23'd0, q, sout}, {23'd0, 8'h81, 1'b1});

    // shr with sin=1 from 0F: 87, C3, E1, F0 with sout=1 each time
    setin(1'b1, 3'b001, 8'h0F, 1'b1, 1'b0, 4'd0); tick();
    mode = 3'b011;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("shr_sout", {31'd0, sout}, 32'd1);
    end
    chk("shr_q", {24'd0, q}, 32'hF0);

    // en=0 holds everything
    setin(1'b0, 3'b111, 8'h00, 1'b0, 1'b0, 4'd0); tick();
    chk("en0_hold", {24'd0, q}, 32'hF0);

    // sequenced shl x3, then with two pause cycles
    for (int pass = 0; pass < 2; pass++) begin
      setin(1'b1, 3'b001, 8'h01, 1'b0, 1'b0, 4'd0); tick();
      setin(1'b1, 3'b010, 8'h00, 1'b0, 1'b1, 4'd3); tick();
      chk("seq_start_q", {24'd0, q}, 32'h01);
      start = 1'b0; mode = 3'b111;
      nb = 0; g = 0; ndone = 0;
      while (busy === 1'b1 && g < 40) begin
        nb++;
        en = (pass == 1 && (nb == 2 || nb == 3)) ? 1'b0 : 1'b1;
        tick();
        if (done === 1'b1 && busy === 1'b1) ndone++;
        g++;
      end
      chk("seq_busy_cycles", nb, pass ? 32'd5 : 32'd3);
      chk("seq_q", {24'd0, q}, 32'h08);
      chk("seq_done", {31'd0, done}, 32'd1);
      chk("seq_early_done", ndone, 32'd0);
      en = 1'b0; tick();
      chk("seq_done_once", {31'd0, done}, 32'd0);
    end

    // nshift=0 start: done next cycle, q unchanged
    setin(1'b1, 3'b100, 8'h00, 1'b0, 1'b1, 4'd0); tick();
    chk("n0_done", {23'd0, q, done}, {23'd0, 8'h08, 1'b1});
    start = 1'b0; en = 1'b0; tick();

    // abort by reset mid-sequence, then a non-shift start is ignored
    setin(1'b1, 3'b011, 8'h00, 1'b1, 1'b1, 4'd5); tick();
    start = 1'b0; tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("abort", {22'd0, q, busy, done}, {22'd0, 8'hA5, 2'b00});
    setin(1'b0, 3'b001, 8'h3C, 1'b0, 1'b1, 4'd3); tick();
    chk("nonshift_start", {23'd0, q, busy}, {23'd0, 8'hA5, 1'b0});

    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 63) == 0);
      en     = ($urandom_range(0, 3) != 0);
      mode   = 3'($urandom_range(0, 7));
      d      = 8'($urandom);
      sin    = 1'($urandom);
      start  = ($urandom_range(0, 5) == 0);
      nshift = 4'($urandom_range(0, 15));
      tick();
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
